storage_access_arbiter: RTL and testbench



---
 rtl/storage_access_arbiter_pkg.sv | 65 ++++++
 rtl/storage_access_arbiter_rr_pick3.sv | 48 ++++
 rtl/storage_access_arbiter.sv | 177 +++++++++++++++++
 tb/tb_storage_access_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/storage_access_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// storage_access_arbiter_pkg
// Shared definitions for the matrix-storage arbiter:
//   - top-level FSM state codes (must match the top FSM encoding)
//   - requester indices (IN, CALC, DISP) used for req/gnt/rvalid bit positions
//   - arbiter FSM state encoding
//   - helpers: eligibility mask per top-FSM state, owner one-hot per arbiter state
// -----------------------------------------------------------------------------
package storage_access_arbiter_pkg;

   // Top FSM state codes, shared with the top-level controller
   localparam logic [3:0] S_INPUT      = 4'd1;
   localparam logic [3:0] S_DISPLAY    = 4'd3;
   localparam logic [3:0] S_CALCULATE  = 4'd7;
   localparam logic [3:0] S_RESULT_OUT = 4'd8;

   // Requester indices into req/gnt/rvalid vectors
   localparam int unsigned IN    = 0;
   localparam int unsigned CALC  = 1;
   localparam int unsigned DISP  = 2;
   localparam int unsigned N_REQ = 3;

   // Burst counter width; holds MAX_BURST up to 255
   localparam int unsigned CNT_W = 8;

   // Owner states are encoded as requester index + 1
   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_OWN_IN   = 2'd1,
      S_OWN_CALC = 2'd2,
      S_OWN_DISP = 2'd3
   } arb_state_e;

   // Which requesters may touch storage in a given top-FSM state
   function automatic logic [N_REQ-1:0] elig_mask(input logic [3:0] fsm_state);
      logic [N_REQ-1:0] m;
      m = '0;
      case (fsm_state)
         S_INPUT: begin
            m[IN]   = 1'b1;
            m[DISP] = 1'b1;
         end
         S_CALCULATE: begin
            m[CALC] = 1'b1;
            m[DISP] = 1'b1;
         end
         S_DISPLAY, S_RESULT_OUT: m[DISP] = 1'b1;
         default: m = '0;
      endcase
      return m;
   endfunction

   // One-hot of the requester owning storage in arbiter state s (0 when idle)
   function automatic logic [N_REQ-1:0] owner_onehot(input arb_state_e s);
      logic [N_REQ-1:0] oh;
      case (s)
         S_OWN_IN:   oh = 3'b001;
         S_OWN_CALC: oh = 3'b010;
         S_OWN_DISP: oh = 3'b100;
         default:    oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/storage_access_arbiter_rr_pick3.sv
// -----------------------------------------------------------------------------
// rr_pick3
// Combinational 3-way round-robin picker. Returns the first requester that is
// both requesting and eligible, searching from i_ptr upward with wrap-around
// (0 -> 1 -> 2 -> 0).
// Ports:
//   i_req  [2:0]  request vector
//   i_elig [2:0]  eligibility mask
//   i_ptr  [1:0]  highest-priority index this cycle (0..2)
//   o_win  [2:0]  one-hot winner, all zero when no candidate
// -----------------------------------------------------------------------------
module rr_pick3
   import storage_access_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic [N_REQ-1:0] i_elig,
   input  logic [1:0]       i_ptr,
   output logic [N_REQ-1:0] o_win
);

   logic [N_REQ-1:0] w_cand;

   assign w_cand = i_req & i_elig;

   always_comb begin
      // NOTE: default assigned before the case so every path drives o_win (no latch).
      o_win = '0;
      case (i_ptr)
         2'd1: begin
            if      (w_cand[1]) o_win = 3'b010;
            else if (w_cand[2]) o_win = 3'b100;
            else if (w_cand[0]) o_win = 3'b001;
         end
         2'd2: begin
            if      (w_cand[2]) o_win = 3'b100;
            else if (w_cand[0]) o_win = 3'b001;
            else if (w_cand[1]) o_win = 3'b010;
         end
         // Pointer value 3 is never produced; treat it like 0
         default: begin
            if      (w_cand[0]) o_win = 3'b001;
            else if (w_cand[1]) o_win = 3'b010;
            else if (w_cand[2]) o_win = 3'b100;
         end
      endcase
   end

endmodule

// File: rtl/storage_access_arbiter.sv
// -----------------------------------------------------------------------------
// storage_access_arbiter
// Shares the single-port matrix storage between Input (write), Calculator
// (read/write) and Display (read-only) using req/gnt handshakes, eligibility
// masks derived from the top FSM state, round-robin fairness with a burst
// limit, and per-requester read-valid tagging for the 1-cycle storage read.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   w_state[3:0]                      top FSM state code
//   w_<in|calc|disp>_req              request, held for the whole burst
//   w_<in|calc|disp>_addr[ADDR_W]     access address
//   w_<in|calc>_data[DATA_W], _we     write data / write enable
//   w_<in|calc|disp>_gnt              registered grant
//   w_<in|calc|disp>_rvalid           read data valid for that requester
//   w_rdata[DATA_W]                   shared read data (storage passthrough)
//   w_storage_addr/_data/_we          to storage (all 0 outside access cycles)
//   w_storage_rdata[DATA_W]           from storage, valid 1 cycle after address
// -----------------------------------------------------------------------------
module storage_access_arbiter
   import storage_access_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_BURST = 16
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        w_state,
   input  logic              w_in_req,
   input  logic              w_calc_req,
   input  logic              w_disp_req,
   input  logic [ADDR_W-1:0] w_in_addr,
   input  logic [ADDR_W-1:0] w_calc_addr,
   input  logic [ADDR_W-1:0] w_disp_addr,
   input  logic [DATA_W-1:0] w_in_data,
   input  logic [DATA_W-1:0] w_calc_data,
   input  logic              w_in_we,
   input  logic              w_calc_we,
   output logic              w_in_gnt,
   output logic              w_calc_gnt,
   output logic              w_disp_gnt,
   output logic              w_in_rvalid,
   output logic              w_calc_rvalid,
   output logic              w_disp_rvalid,
   output logic [DATA_W-1:0] w_rdata,
   output logic [ADDR_W-1:0] w_storage_addr,
   output logic [DATA_W-1:0] w_storage_data,
   output logic              w_storage_we,
   input  logic [DATA_W-1:0] w_storage_rdata
);

   localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   arb_state_e        r_arb, w_arb_nxt;
   logic [1:0]        r_ptr, w_ptr_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [N_REQ-1:0]  r_gnt, r_rvalid, w_rvalid_nxt;
   logic [N_REQ-1:0]  w_req, w_elig, w_win, w_own_oh;

   logic              w_own_req;
   logic [ADDR_W-1:0] w_own_addr;
   logic [DATA_W-1:0] w_own_data;
   logic              w_own_we;
   logic              w_access;
   logic              w_waiter;

   assign w_req    = {w_disp_req, w_calc_req, w_in_req};
   assign w_elig   = elig_mask(w_state);
   assign w_own_oh = owner_onehot(r_arb);

   rr_pick3 u_pick (
      .i_req  (w_req),
      .i_elig (w_elig),
      .i_ptr  (r_ptr),
      .o_win  (w_win)
   );

   // Current owner's request and access fields; display is always a read
   always_comb begin
      w_own_req  = 1'b0;
      w_own_addr = '0;
      w_own_data = '0;
      w_own_we   = 1'b0;
      case (r_arb)
         S_OWN_IN: begin
            w_own_req  = w_in_req;
            w_own_addr = w_in_addr;
            w_own_data = w_in_data;
            w_own_we   = w_in_we;
         end
         S_OWN_CALC: begin
            w_own_req  = w_calc_req;
            w_own_addr = w_calc_addr;
            w_own_data = w_calc_data;
            w_own_we   = w_calc_we;
         end
         S_OWN_DISP: begin
            w_own_req  = w_disp_req;
            w_own_addr = w_disp_addr;
         end
         default: ;
      endcase
   end

   // An access needs an owner that still requests and is still eligible;
   // losing eligibility gates the storage outputs in the very same cycle.
   assign w_access = w_own_req && ((w_own_oh & w_elig) != '0);
   assign w_waiter = (w_req & w_elig & ~w_own_oh) != '0;
   assign w_cnt_inc = (r_cnt == BURST_LIM) ? r_cnt : r_cnt + CNT_ONE;

   assign w_storage_addr = w_access ? w_own_addr : '0;
   assign w_storage_data = w_access ? w_own_data : '0;
   assign w_storage_we   = w_access & w_own_we;

   // Next-state logic
   always_comb begin
      w_arb_nxt    = r_arb;
      w_ptr_nxt    = r_ptr;
      w_cnt_nxt    = r_cnt;
      w_rvalid_nxt = '0;
      if (r_arb == S_IDLE) begin
         if (w_win != '0) begin
            w_cnt_nxt = '0;
            case (w_win)
               3'b001: begin
                  w_arb_nxt = S_OWN_IN;
                  w_ptr_nxt = 2'(CALC);
               end
               3'b010: begin
                  w_arb_nxt = S_OWN_CALC;
                  w_ptr_nxt = 2'(DISP);
               end
               default: begin
                  w_arb_nxt = S_OWN_DISP;
                  w_ptr_nxt = 2'(IN);
               end
            endcase
         end
      end else if (!w_access) begin
         // Release (req low) or revoke (owner no longer eligible)
         w_arb_nxt = S_IDLE;
      end else begin
         w_cnt_nxt = w_cnt_inc;
         if (!w_own_we) w_rvalid_nxt = w_own_oh;
         // Hand over once the burst quota is used and someone is waiting;
         // the pointer already points past the owner, so the waiter wins.
         if ((w_cnt_inc == BURST_LIM) && w_waiter) w_arb_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_arb    <= S_IDLE;
         r_ptr    <= 2'(IN);
         r_cnt    <= '0;
         r_gnt    <= '0;
         r_rvalid <= '0;
      end else begin
         // NOTE: non-blocking so every flop updates from pre-edge values.
         r_arb    <= w_arb_nxt;
         r_ptr    <= w_ptr_nxt;
         r_cnt    <= w_cnt_nxt;
         r_gnt    <= owner_onehot(w_arb_nxt);
         r_rvalid <= w_rvalid_nxt;
      end
   end

   assign w_in_gnt      = r_gnt[IN];
   assign w_calc_gnt    = r_gnt[CALC];
   assign w_disp_gnt    = r_gnt[DISP];
   assign w_in_rvalid   = r_rvalid[IN];
   assign w_calc_rvalid = r_rvalid[CALC];
   assign w_disp_rvalid = r_rvalid[DISP];
   assign w_rdata       = w_storage_rdata;

endmodule

// File: tb/tb_storage_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_storage_access_arbiter
// Directed bench for storage_access_arbiter with MAX_BURST = 4 and a small
// synchronous single-port storage model. Inputs change on the falling edge;
// outputs are checked 1 time unit later.
// -----------------------------------------------------------------------------
module tb_storage_access_arbiter;

   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned MAX_BURST = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [3:0]        w_state;
   logic              w_in_req, w_calc_req, w_disp_req;
   logic [ADDR_W-1:0] w_in_addr, w_calc_addr, w_disp_addr;
   logic [DATA_W-1:0] w_in_data, w_calc_data;
   logic              w_in_we, w_calc_we;
   logic              w_in_gnt, w_calc_gnt, w_disp_gnt;
   logic              w_in_rvalid, w_calc_rvalid, w_disp_rvalid;
   logic [DATA_W-1:0] w_rdata;
   logic [ADDR_W-1:0] w_storage_addr;
   logic [DATA_W-1:0] w_storage_data;
   logic              w_storage_we;
   logic [DATA_W-1:0] w_storage_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected {calc_gnt, disp_gnt, storage_we, disp_rvalid} per cycle of the
   // round-robin run: 4 CALC writes, bubble, 4 DISP reads, bubble, CALC again.
   logic [3:0] rr_exp [12] = '{4'b0000, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0000,
                               4'b0100, 4'b0101, 4'b0101, 4'b0101, 4'b0001, 4'b1010};

   storage_access_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .w_state         (w_state),
      .w_in_req        (w_in_req),
      .w_calc_req      (w_calc_req),
      .w_disp_req      (w_disp_req),
      .w_in_addr       (w_in_addr),
      .w_calc_addr     (w_calc_addr),
      .w_disp_addr     (w_disp_addr),
      .w_in_data       (w_in_data),
      .w_calc_data     (w_calc_data),
      .w_in_we         (w_in_we),
      .w_calc_we       (w_calc_we),
      .w_in_gnt        (w_in_gnt),
      .w_calc_gnt      (w_calc_gnt),
      .w_disp_gnt      (w_disp_gnt),
      .w_in_rvalid     (w_in_rvalid),
      .w_calc_rvalid   (w_calc_rvalid),
      .w_disp_rvalid   (w_disp_rvalid),
      .w_rdata         (w_rdata),
      .w_storage_addr  (w_storage_addr),
      .w_storage_data  (w_storage_data),
      .w_storage_we    (w_storage_we),
      .w_storage_rdata (w_storage_rdata)
   );

   always #5 clk = ~clk;

   // Single-port storage model with 1-cycle synchronous read
   logic [DATA_W-1:0] mem [256];
   always @(posedge clk) begin
      if (w_storage_we) mem[w_storage_addr] <= w_storage_data;
      w_storage_rdata <= mem[w_storage_addr];
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic clear_reqs();
      w_in_req    = 1'b0;
      w_calc_req  = 1'b0;
      w_disp_req  = 1'b0;
      w_in_addr   = '0;
      w_calc_addr = '0;
      w_disp_addr = '0;
      w_in_data   = '0;
      w_calc_data = '0;
      w_in_we     = 1'b0;
      w_calc_we   = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_reqs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      w_state = 4'd7;
      clear_reqs();
      #1;
      // ---------------- reset and idle ----------------
      check("rst_gnt",    {w_in_gnt, w_calc_gnt, w_disp_gnt}, 3'b000);
      check("rst_rvalid", {w_in_rvalid, w_calc_rvalid, w_disp_rvalid}, 3'b000);
      check("rst_port",   {w_storage_we, w_storage_addr, w_storage_data}, 41'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk); #1;
         check("idle_gnt",  {w_in_gnt, w_calc_gnt, w_disp_gnt}, 3'b000);
         check("idle_port", {w_storage_we, w_storage_addr, w_storage_data}, 41'd0);
      end

      // ---------------- basic write ----------------
      @(negedge clk);
      w_state = 4'd1; w_in_req = 1'b1; w_in_addr = 8'h05; w_in_data = 32'hDEADBEEF; w_in_we = 1'b1;
      #1;
      check("wr_gnt_lat", w_in_gnt, 1'b0);
      @(negedge clk); #1;
      check("wr_gnt",  w_in_gnt, 1'b1);
      check("wr_port", {w_storage_we, w_storage_addr, w_storage_data}, {1'b1, 8'h05, 32'hDEADBEEF});
      @(negedge clk);
      w_in_req = 1'b0;
      #1;
      check("wr_rel_we",    w_storage_we, 1'b0);
      check("wr_no_rvalid", w_in_rvalid, 1'b0);
      @(negedge clk);
      // ---------------- readback ----------------
      w_state = 4'd3; w_disp_req = 1'b1; w_disp_addr = 8'h05;
      #1;
      check("wr_gnt_drop", {w_in_gnt, w_disp_gnt}, 2'b00);
      @(negedge clk); #1;
      check("rd_gnt",  w_disp_gnt, 1'b1);
      check("rd_port", {w_storage_we, w_storage_addr, w_storage_data}, {1'b0, 8'h05, 32'h0});
      @(negedge clk);
      w_disp_req = 1'b0;
      #1;
      check("rd_rvalid", {w_in_rvalid, w_calc_rvalid, w_disp_rvalid}, 3'b001);
      check("rd_data",   w_rdata, 32'hDEADBEEF);
      @(negedge clk); #1;
      check("rd_rvalid_pulse", {w_disp_rvalid, w_disp_gnt}, 2'b00);

      // ---------------- eligibility and revoke ----------------
      w_state = 4'd7;
      w_calc_req = 1'b1; w_calc_we = 1'b1; w_calc_addr = 8'h10; w_calc_data = 32'h11112222;
      w_in_req = 1'b1;
      #1;
      check("rvk_gnt_lat", w_calc_gnt, 1'b0);
      @(negedge clk); #1;
      check("rvk_gnt",  {w_in_gnt, w_calc_gnt}, 2'b01);
      check("rvk_port", {w_storage_we, w_storage_addr, w_storage_data}, {1'b1, 8'h10, 32'h11112222});
      @(negedge clk);
      w_state = 4'd3;
      #1;
      check("rvk_we_gated", {w_storage_we, w_storage_addr}, 9'd0);
      check("rvk_gnt_held", w_calc_gnt, 1'b1);
      @(negedge clk); #1;
      check("rvk_gnt_drop", w_calc_gnt, 1'b0);
      repeat (2) begin
         @(negedge clk); #1;
         check("rvk_inelig", {w_in_gnt, w_calc_gnt}, 2'b00);
      end
      w_state = 4'd7;
      w_calc_req = 1'b0;
      repeat (3) begin
         @(negedge clk); #1;
         check("in_inelig_calc", w_in_gnt, 1'b0);
      end

      // ---------------- round robin and burst limit ----------------
      do_reset();
      @(negedge clk);
      w_state = 4'd7;
      w_calc_req = 1'b1; w_calc_we = 1'b1; w_calc_addr = 8'h30; w_calc_data = 32'hC0C0C0C0;
      w_disp_req = 1'b1; w_disp_addr = 8'h10;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         check($sformatf("rr_c%0d", c), {w_calc_gnt, w_disp_gnt, w_storage_we, w_disp_rvalid}, rr_exp[c]);
         if (c == 10) begin
            check("handover_rdata",  w_rdata, 32'h11112222);
            check("handover_calc_rv", w_calc_rvalid, 1'b0);
         end
      end
      // Lone requester keeps ownership well past the burst limit
      w_disp_req = 1'b0;
      repeat (8) begin
         @(negedge clk); #1;
         check("lone_own", {w_calc_gnt, w_storage_we}, 2'b11);
      end

      // ---------------- reset mid-burst ----------------
      @(negedge clk); #1;
      check("mid_pre", {w_calc_gnt, w_storage_we}, 2'b11);
      rst_n = 1'b0;
      #1;
      check("mid_rst", {w_calc_gnt, w_storage_we, w_storage_addr, w_storage_data}, 42'd0);
      clear_reqs();
      @(negedge clk);
      rst_n = 1'b1;

      // ---------------- simultaneous requests ----------------
      @(negedge clk);
      w_state = 4'd1;
      w_in_req = 1'b1; w_in_we = 1'b1; w_in_addr = 8'h40; w_in_data = 32'h40404040;
      w_disp_req = 1'b1; w_disp_addr = 8'h10;
      #1;
      check("sim_lat", {w_in_gnt, w_calc_gnt, w_disp_gnt}, 3'b000);
      @(negedge clk); #1;
      check("sim_in_wins", {w_in_gnt, w_calc_gnt, w_disp_gnt}, 3'b100);
      @(negedge clk);
      w_in_req = 1'b0;
      #1;
      check("sim_in_rel", {w_in_gnt, w_calc_gnt, w_disp_gnt}, 3'b100);
      @(negedge clk); #1;
      check("sim_bubble", {w_in_gnt, w_calc_gnt, w_disp_gnt}, 3'b000);
      @(negedge clk); #1;
      check("sim_disp", {w_in_gnt, w_calc_gnt, w_disp_gnt}, 3'b001);
      clear_reqs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
